// File: rtl/dmem_sb_pkg.sv
// Shared types and defaults for the posted data-memory store buffer.
//   sb_state_e : memory-side controller states
//   sb_entry_t : one buffered store {byte address, data} at default widths
//   SB_*       : default DEPTH / ADDR_W / DATA_W
package dmem_sb_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    RD_WAIT = 2'd2,
    RD_DONE = 2'd3
  } sb_state_e;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/dmem_store_buffer_store_queue.sv
// store_queue: circular FIFO of posted stores with a youngest-first
// word-address match search used for load forwarding.
//   clk, rst_n           : clock, synchronous active-low reset
//   push, push_addr/data : enqueue at tail (caller guarantees !full)
//   pop                  : retire head (caller guarantees count>0)
//   head_addr/data       : oldest entry, drives the memory write
//   count, full          : occupancy
//   lookup_word          : word address (byte address >> 2) of a load
//   hit, hit_data        : youngest valid entry matching lookup_word
module store_queue
  import dmem_sb_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [ADDR_W-1:0]       push_addr,
  input  logic [DATA_W-1:0]       push_data,
  input  logic                    pop,
  output logic [ADDR_W-1:0]       head_addr,
  output logic [DATA_W-1:0]       head_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  input  logic [ADDR_W-3:0]       lookup_word,
  output logic                    hit,
  output logic [DATA_W-1:0]       hit_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             entries_q [DEPTH];
  logic [PTR_W-1:0]   head_q;
  logic [PTR_W-1:0]   tail_q;
  logic [CNT_W-1:0]   count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the entry array is deliberately not reset; an entry is valid only
  // when its distance from head is below count, so stale contents are inert.
  always_ff @(posedge clk) begin
    if (push) entries_q[tail_q] <= '{addr: push_addr, data: push_data};
  end

  assign head_addr = entries_q[head_q].addr;
  assign head_data = entries_q[head_q].data;
  assign count     = count_q;
  assign full      = (count_q == CNT_W'(DEPTH));

  // Walk oldest to youngest; a later match overwrites an earlier one, so the
  // result is the youngest matching store.
  // NOTE: every output of this always_comb gets a default first, so no path
  // leaves a value held and no latch is inferred.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) &&
          (entries_q[idx].addr[ADDR_W-1:2] == lookup_word)) begin
        hit      = 1'b1;
        hit_data = entries_q[idx].data;
      end
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posted store buffer in front of a multi-cycle data
// memory. Stores retire into store_queue without stalling; loads forward
// from the youngest matching buffered store or fetch from memory under stall.
//   clk_i, rst_i           : clock, synchronous active-low reset
//   MemRead_i, MemWrite_i  : MEM-stage load / store (both set = store)
//   addr_i, wdata_i        : byte address, store data
//   rdata_o, stall_o       : load data to MEMWB, pipeline freeze
//   mem_req_o .. mem_wdata_o : memory request bus (held stable until ack)
//   mem_ack_i, mem_rdata_i : single-cycle completion, read data
module dmem_store_buffer
  import dmem_sb_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  sb_state_e         state_q, state_d;
  logic              load_req, load_miss, push, pop, xfer_done;
  logic              q_full, q_hit;
  logic [CNT_W-1:0]  q_count;
  logic [ADDR_W-1:0] q_head_addr;
  logic [DATA_W-1:0] q_head_data, q_hit_data;
  logic [DATA_W-1:0] rd_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  // A simultaneous read+write is a store; a store never pushes into a full
  // queue even if the head drains this cycle -- it retries next cycle.
  assign load_req  = MemRead_i & ~MemWrite_i;
  assign load_miss = load_req & ~q_hit;
  assign push      = MemWrite_i & ~q_full;
  assign xfer_done = mem_req_q & mem_ack_i;
  assign pop       = (state_q == WR_WAIT) & xfer_done;

  store_queue #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_queue (
    .clk         (clk_i),
    .rst_n       (rst_i),
    .push        (push),
    .push_addr   (addr_i),
    .push_data   (wdata_i),
    .pop         (pop),
    .head_addr   (q_head_addr),
    .head_data   (q_head_data),
    .count       (q_count),
    .full        (q_full),
    .lookup_word (addr_i[ADDR_W-1:2]),
    .hit         (q_hit),
    .hit_data    (q_hit_data)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state. A pending load miss wins over draining: the pipeline is
  // frozen on it, while buffered stores can wait.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load_miss)                state_d = RD_WAIT;
        else if (q_count != '0)       state_d = WR_WAIT;
      end
      WR_WAIT: if (xfer_done) state_d = IDLE;
      RD_WAIT: if (xfer_done) state_d = RD_DONE;
      RD_DONE:                state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Outputs to the pipeline. A hit cannot coexist with RD_DONE: a miss
  // proved no entry targets the word and the frozen pipeline adds none.
  always_comb begin
    stall_o = 1'b0;
    rdata_o = '0;
    if (MemWrite_i) begin
      stall_o = q_full;
    end else if (load_req) begin
      if (q_hit)                   rdata_o = q_hit_data;
      else if (state_q == RD_DONE) rdata_o = rd_q;
      else                         stall_o = 1'b1;
    end
  end

  // Memory bus registers: loaded once on entry to a request state so the
  // fields stay stable until ack, cleared whenever no request is open.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_d)
        WR_WAIT: if (state_q != WR_WAIT) begin
          mem_req_q   <= 1'b1;
          mem_we_q    <= 1'b1;
          mem_addr_q  <= q_head_addr;
          mem_wdata_q <= q_head_data;
        end
        RD_WAIT: if (state_q != RD_WAIT) begin
          mem_req_q   <= 1'b1;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= addr_i;
          mem_wdata_q <= '0;
        end
        default: begin
          mem_req_q   <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i)                                rd_q <= '0;
    else if (state_q == RD_WAIT && xfer_done)  rd_q <= mem_rdata_i;
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed self-checking bench for dmem_store_buffer (DEPTH=4, 32/32).
// Inputs are driven 2 ns after the rising edge, the memory responder acts
// 1 ns after the edge, and combinational outputs are sampled on the
// falling edge.
module tb_dmem_store_buffer;
  import dmem_sb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        MemRead_i = 1'b0;
  logic        MemWrite_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  dmem_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          lat = 0;
  bit          hold = 1'b0;
  logic [31:0] rd_val = '0;
  int          mcnt = 0;
  sb_entry_t   wlog[$];

  // Memory responder: ack arrives `lat` cycles after the request is first
  // seen; `hold` freezes it. Completed writes are logged in order.
  always @(posedge clk) begin
    #1;
    if (mem_ack_i) begin
      mem_ack_i = 1'b0;
      mcnt      = 0;
    end else if (mem_req_o && !hold) begin
      if (mcnt == lat) begin
        mem_ack_i = 1'b1;
        if (mem_we_o) wlog.push_back('{addr: mem_addr_o, data: mem_wdata_o});
        else          mem_rdata_i = rd_val;
      end else begin
        mcnt++;
      end
    end else if (!mem_req_o) begin
      mcnt = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    sb_entry_t e;
    e = (idx < wlog.size()) ? wlog[idx] : '0;
    check(tag, e, {a, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_idle();
    MemRead_i = 1'b0; MemWrite_i = 1'b0; addr_i = '0; wdata_i = '0;
  endtask

  task automatic set_store(input logic [31:0] a, input logic [31:0] d);
    MemRead_i = 1'b0; MemWrite_i = 1'b1; addr_i = a; wdata_i = d;
  endtask

  task automatic set_load(input logic [31:0] a);
    MemRead_i = 1'b1; MemWrite_i = 1'b0; addr_i = a; wdata_i = '0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((dut.q_count != '0 || mem_req_o) && n < 300) begin
      tick();
      n++;
    end
    check(tag, n < 300, 1'b1);
  endtask

  initial begin
    int n;
    int base;
    int pushed;
    int guard;
    bit last_push;
    logic [31:0] rd_addr_seen;

    // Reset state.
    repeat (2) tick();
    sample();
    check("rst_req",   mem_req_o,   1'b0);
    check("rst_we",    mem_we_o,    1'b0);
    check("rst_addr",  mem_addr_o,  32'h0);
    check("rst_wdata", mem_wdata_o, 32'h0);
    check("rst_stall", stall_o,     1'b0);
    check("rst_rdata", rdata_o,     32'h0);
    check("rst_count", dut.q_count, 3'd0);
    check("rst_rdq",   dut.rd_q,    32'h0);
    rst_i = 1'b1;

    // Reset in the middle of a write drain with 3 entries queued.
    hold = 1'b1; lat = 1;
    tick(); set_store(32'h60, 32'h1);
    tick(); set_store(32'h64, 32'h2);
    tick(); set_store(32'h68, 32'h3);
    tick(); set_idle();
    sample();
    check("mr_count_pre", dut.q_count, 3'd3);
    check("mr_req_pre",   mem_req_o,   1'b1);
    check("mr_addr_pre",  mem_addr_o,  32'h60);
    tick(); rst_i = 1'b0;
    tick(); rst_i = 1'b1;
    sample();
    check("mr_req_post",   mem_req_o,   1'b0);
    check("mr_count_post", dut.q_count, 3'd0);
    hold = 1'b0; rd_val = 32'h1234;
    tick(); set_load(32'h64);
    n = 0;
    sample();
    while (stall_o && n < 20) begin n++; tick(); sample(); end
    check("mr_miss_stall_cycles", n, 3);
    check("mr_miss_rdata", rdata_o, 32'h1234);
    tick(); set_idle();
    sample();
    check("mr_after_stall", stall_o, 1'b0);
    check("mr_after_rdata", rdata_o, 32'h0);
    check("mr_no_writes",   wlog.size(), 0);

    // Three stores, latency 2: no stall, in-order writes.
    lat = 2; base = wlog.size();
    tick(); set_store(32'h10, 32'h1);
    sample();
    check("a_stall0", stall_o, 1'b0);
    tick(); set_store(32'h14, 32'h2);
    sample();
    check("a_stall1", stall_o, 1'b0);
    check("a_req1",   mem_req_o, 1'b0);
    check("a_count1", dut.q_count, 3'd1);
    tick(); set_store(32'h18, 32'h3);
    sample();
    check("a_stall2", stall_o, 1'b0);
    check("a_req2",   mem_req_o, 1'b1);
    check("a_we2",    mem_we_o, 1'b1);
    check("a_addr2",  mem_addr_o, 32'h10);
    check("a_wdata2", mem_wdata_o, 32'h1);
    check("a_count2", dut.q_count, 3'd2);
    tick(); set_idle();
    drain("a_drain");
    check_log("a_log0", base + 0, 32'h10, 32'h1);
    check_log("a_log1", base + 1, 32'h14, 32'h2);
    check_log("a_log2", base + 2, 32'h18, 32'h3);

    // Youngest-match forwarding, no coalescing, read+write as store.
    hold = 1'b1; base = wlog.size();
    tick(); set_store(32'h20, 32'hA);
    sample();
    check("b_store_rdata", rdata_o, 32'h0);
    tick(); set_store(32'h20, 32'hB);
    tick(); set_load(32'h20);
    sample();
    check("b_hit_rdata", rdata_o, 32'hB);
    check("b_hit_stall", stall_o, 1'b0);
    tick(); set_load(32'h22);
    sample();
    check("b_hit_byte_rdata", rdata_o, 32'hB);
    check("b_hit_byte_stall", stall_o, 1'b0);
    tick(); set_load(32'h24);
    sample();
    check("b_miss_stall", stall_o, 1'b1);
    check("b_miss_rdata", rdata_o, 32'h0);
    tick(); MemRead_i = 1'b1; MemWrite_i = 1'b1; addr_i = 32'h75; wdata_i = 32'hC;
    sample();
    check("b_rw_stall", stall_o, 1'b0);
    check("b_rw_rdata", rdata_o, 32'h0);
    tick(); set_idle();
    sample();
    check("b_count", dut.q_count, 3'd3);
    hold = 1'b0;
    drain("b_drain");
    check_log("b_log0", base + 0, 32'h20, 32'hA);
    check_log("b_log1", base + 1, 32'h20, 32'hB);
    check_log("b_log2", base + 2, 32'h75, 32'hC);

    // DEPTH+1 stores with latency 5: full stall until the first ack.
    lat = 5; base = wlog.size();
    tick(); set_store(32'h100, 32'h50);
    tick(); set_store(32'h104, 32'h51);
    tick(); set_store(32'h108, 32'h52);
    tick(); set_store(32'h10C, 32'h53);
    sample();
    check("c_stall3", stall_o, 1'b0);
    check("c_count3", dut.q_count, 3'd3);
    tick(); set_store(32'h110, 32'h54);
    n = 0;
    sample();
    while (stall_o && n < 20) begin n++; tick(); sample(); end
    check("c_full_stall_cycles", n, 4);
    check("c_count_after_ack", dut.q_count, 3'd3);
    tick(); set_idle();
    sample();
    check("c_count_refill", dut.q_count, 3'd4);
    drain("c_drain");
    for (int i = 0; i < 5; i++)
      check_log($sformatf("c_log%0d", i), base + i, 32'h100 + 32'(4 * i), 32'h50 + 32'(i));

    // Load miss behind an in-flight write drain.
    lat = 3; rd_val = 32'hDEAD; base = wlog.size();
    tick(); set_store(32'h30, 32'h7);
    tick(); set_idle();
    sample();
    check("d_req_idle", mem_req_o, 1'b0);
    tick(); set_load(32'h40);
    n = 0; rd_addr_seen = '0;
    sample();
    while (stall_o && n < 40) begin
      if (mem_req_o && !mem_we_o) rd_addr_seen = mem_addr_o;
      n++;
      tick();
      sample();
    end
    check("d_stall_cycles", n, 9);
    check("d_rd_addr",      rd_addr_seen, 32'h40);
    check("d_done_rdata",   rdata_o, 32'hDEAD);
    check("d_done_req",     mem_req_o, 1'b0);
    tick(); set_idle();
    sample();
    check("d_post_stall", stall_o, 1'b0);
    check("d_post_rdata", rdata_o, 32'h0);
    check_log("d_log0", base, 32'h30, 32'h7);

    // Push and drain-ack in the same cycle at count 2, wrapping pointers.
    lat = 1; hold = 1'b1; base = wlog.size();
    tick(); set_store(32'h180, 32'h80);
    tick(); set_store(32'h184, 32'h81);
    tick(); set_idle();
    sample();
    check("e_count_pre", dut.q_count, 3'd2);
    hold = 1'b0; pushed = 0; guard = 0; last_push = 1'b0;
    while (pushed < 8 && guard < 100) begin
      tick(); set_idle();
      if (last_push) begin
        check($sformatf("e_count_after_push%0d", pushed), dut.q_count, 3'd2);
        last_push = 1'b0;
      end
      if (mem_ack_i) begin
        set_store(32'h200 + 32'(4 * pushed), 32'h900 + 32'(pushed));
        pushed++;
        last_push = 1'b1;
      end
      guard++;
    end
    check("e_pushed", pushed, 8);
    tick(); set_idle();
    if (last_push) check("e_count_after_last", dut.q_count, 3'd2);
    drain("e_drain");
    check_log("e_log_pre0", base + 0, 32'h180, 32'h80);
    check_log("e_log_pre1", base + 1, 32'h184, 32'h81);
    for (int i = 0; i < 8; i++)
      check_log($sformatf("e_log%0d", i), base + 2 + i, 32'h200 + 32'(4 * i), 32'h900 + 32'(i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
